// File: rtl/he_round_pkg.sv
// Shared rounding-mode definitions for the HE rescale datapath.
// No logic; constants and types only.
// Imported by the rounding stage, its interface and the bench.
package he_round_pkg;

  typedef logic [1:0] rnd_mode_t;

  localparam rnd_mode_t RND_TRUNC   = 2'd0;
  localparam rnd_mode_t RND_HALF_UP = 2'd1;
  localparam rnd_mode_t RND_EVEN    = 2'd2;
  localparam rnd_mode_t RND_CEIL    = 2'd3;

endpackage

// File: rtl/scale_round_pipe_if.sv
// Valid/ready bus for the scale-and-round stage: wide dividend in, rounded coefficient out.
// No logic; wiring only.
// Input side stalls on in_ready; output side holds its fields while out_valid && !out_ready.
interface scale_round_pipe_if #(
  parameter int IN_W  = 120,
  parameter int OUT_W = 30,
  parameter int IDX_W = 10
) ();
  import he_round_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  rnd_mode_t        in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  // Producer of input beats and consumer of results.
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_idx, out_last
  );

  // The rounding pipeline itself.
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_idx, out_last
  );

endinterface

// File: rtl/round_incr.sv
// Rounding increment from the quotient LSB, remainder flags and per-beat mode.
// Combinational, zero latency.
// No flow control; evaluated on whatever the S1 register holds.
module round_incr
  import he_round_pkg::*;
(
  input  logic      q_lsb_i,
  input  logic      r_zero_i,
  input  logic      r_gt_half_i,
  input  logic      r_eq_half_i,
  input  rnd_mode_t mode_i,
  output logic      inc_o
);

  // Select the increment rule for the captured mode.
  always_comb begin
    inc_o = 1'b0;
    case (mode_i)
      RND_TRUNC:   inc_o = 1'b0;
      RND_HALF_UP: inc_o = r_gt_half_i | r_eq_half_i;
      RND_EVEN:    inc_o = r_gt_half_i | (r_eq_half_i & q_lsb_i);
      RND_CEIL:    inc_o = ~r_zero_i;
      default:     inc_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/scale_round_pipe.sv
// Divide by 2^SHIFT with selectable rounding, saturation and coefficient indexing.
// Latency 2 cycles (S1 quotient/remainder flags, S2 rounded result), 1 beat/cycle.
// S2 loads when empty or out_ready; S1 advances with S2; in_ready = !S1 valid || S1 advance.
module scale_round_pipe
  import he_round_pkg::*;
#(
  parameter int IN_W  = 120,
  parameter int SHIFT = 90,
  parameter int OUT_W = 30,
  parameter int N     = 1024,
  parameter int IDX_W = $clog2(N)
) (
  input logic               clk,
  input logic               reset,
  scale_round_pipe_if.slave bus
);

  localparam int Q_W = IN_W - SHIFT;
  localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  if (SHIFT < 1 || SHIFT >= IN_W) begin : g_bad_shift
    $error("scale_round_pipe: SHIFT out of range");
  end
  if (OUT_W > Q_W) begin : g_bad_out_w
    $error("scale_round_pipe: OUT_W wider than quotient");
  end

  // Handshake terms
  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  logic s2_load, s1_adv, in_fire, out_fire;

  // S1 payload
  logic [Q_W-1:0]   s1_q_q, s1_q_d;
  logic             s1_rzero_q, s1_rzero_d;
  logic             s1_gt_q, s1_gt_d;
  logic             s1_eq_q, s1_eq_d;
  rnd_mode_t        s1_mode_q, s1_mode_d;
  logic [SHIFT-1:0] rem;

  // S2 payload
  logic [OUT_W-1:0] s2_dat_q, s2_dat_d;
  logic             s2_sat_q, s2_sat_d;
  logic             inc;
  logic [Q_W:0]     sum;

  // Coefficient index
  logic [IDX_W-1:0] idx_q, idx_d;

  assign s2_load  = !s2_vld_q || bus.out_ready;
  assign s1_adv   = s2_load;
  assign bus.in_ready = !s1_vld_q || s1_adv;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = s2_vld_q && bus.out_ready;

  assign rem = bus.in_data[SHIFT-1:0];

  // S1 next state: split the dividend into quotient and remainder classification.
  always_comb begin
    s1_q_d     = bus.in_data[IN_W-1:SHIFT];
    s1_rzero_d = (rem == '0);
    s1_gt_d    = rem[SHIFT-1] && ((rem & ~HALF) != '0);
    s1_eq_d    = (rem == HALF);
    s1_mode_d  = bus.in_mode;
    s1_vld_d   = in_fire || (s1_vld_q && !s1_adv);
  end

  round_incr u_round_incr (
    .q_lsb_i     (s1_q_q[0]),
    .r_zero_i    (s1_rzero_q),
    .r_gt_half_i (s1_gt_q),
    .r_eq_half_i (s1_eq_q),
    .mode_i      (s1_mode_q),
    .inc_o       (inc)
  );

  // S2 next state: add the increment one bit wide and clamp to OUT_W.
  always_comb begin
    sum      = {1'b0, s1_q_q} + {{Q_W{1'b0}}, inc};
    s2_sat_d = |sum[Q_W:OUT_W];
    s2_dat_d = s2_sat_d ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
    s2_vld_d = s2_load ? s1_vld_q : s2_vld_q;
  end

  // Index advances once per output handshake and wraps after N-1.
  always_comb begin
    idx_d = idx_q;
    if (out_fire) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // S1 register: payload captured only on an accepted input beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_q_q     <= '0;
      s1_rzero_q <= 1'b0;
      s1_gt_q    <= 1'b0;
      s1_eq_q    <= 1'b0;
      s1_mode_q  <= RND_TRUNC;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (in_fire) begin
        s1_q_q     <= s1_q_d;
        s1_rzero_q <= s1_rzero_d;
        s1_gt_q    <= s1_gt_d;
        s1_eq_q    <= s1_eq_d;
        s1_mode_q  <= s1_mode_d;
      end
    end
  end

  // S2 register: result only changes when a real beat moves in, so it stays stable under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
      s2_sat_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      s2_vld_q <= s2_vld_d;
      idx_q    <= idx_d;
      if (s2_load && s1_vld_q) begin
        s2_dat_q <= s2_dat_d;
        s2_sat_q <= s2_sat_d;
      end
    end
  end

  assign bus.out_valid = s2_vld_q;
  assign bus.out_data  = s2_dat_q;
  assign bus.out_sat   = s2_sat_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = (idx_q == IDX_LAST);

endmodule

// File: tb/tb_scale_round_pipe.sv
// Self-checking bench for scale_round_pipe: directed rounding cases, stall, wrap and reset.
// Reference model is plain integer arithmetic on the dividend plus a scoreboard queue.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_scale_round_pipe;
  import he_round_pkg::*;

  localparam int IN_W  = 120;
  localparam int SHIFT = 90;
  localparam int OUT_W = 30;
  localparam int N     = 1024;
  localparam int IDX_W = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scale_round_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

  scale_round_pipe #(
    .IN_W(IN_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .N(N), .IDX_W(IDX_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: {sat, data} from the dividend using plain wide integer arithmetic.
  function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] x, input logic [1:0] m);
    logic [IN_W-1:0] q, r, half;
    logic [IN_W:0]   s, maxv;
    logic            inc;
    q    = x >> SHIFT;
    r    = x - (q << SHIFT);
    half = 1;
    half = half << (SHIFT - 1);
    maxv = 1;
    maxv = (maxv << OUT_W) - 1;
    case (m)
      RND_TRUNC:   inc = 1'b0;
      RND_HALF_UP: inc = (r >= half);
      RND_EVEN:    inc = (r > half) || (r == half && (q % 2) == 1);
      default:     inc = (r != 0);
    endcase
    s = {1'b0, q} + inc;
    if (s > maxv) return {1'b1, {OUT_W{1'b1}}};
    return {1'b0, s[OUT_W-1:0]};
  endfunction

  function automatic logic [IN_W-1:0] rand_x();
    logic [127:0]    w;
    logic [IN_W-1:0] x, half;
    w = {$urandom, $urandom, $urandom, $urandom};
    x = w[IN_W-1:0];
    half = 1;
    half = half << (SHIFT - 1);
    case ($urandom_range(0, 4))
      0: x[SHIFT-1:0] = '0;
      1: x[SHIFT-1:0] = half[SHIFT-1:0];
      2: x[IN_W-1:SHIFT] = '1;
      default: ;
    endcase
    return x;
  endfunction

  // Scoreboard and output monitor
  logic [OUT_W:0] sb[$];
  logic [OUT_W:0] mon_e;
  int exp_idx = 0;
  int n_last = 0;
  int last_at_idx = -1;
  int seen_idx = -1;
  int seen_last = -1;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      exp_idx   = 0;
      n_last    = 0;
      seen_idx  = -1;
      seen_last = -1;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty_on_out", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          chk("data", bus.out_data, mon_e[OUT_W-1:0]);
          chk("sat", bus.out_sat, mon_e[OUT_W]);
          chk("idx", bus.out_idx, exp_idx);
          chk("last", bus.out_last, exp_idx == N - 1);
          if (bus.out_last) begin
            n_last++;
            last_at_idx = bus.out_idx;
          end
          seen_idx  = bus.out_idx;
          seen_last = bus.out_last;
          exp_idx = (exp_idx + 1) % N;
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_data, bus.in_mode));
    end
  end

  // Present a beat and hold it until accepted; returns 1 unit after the accepting edge.
  task automatic drive_beat(input logic [IN_W-1:0] x, input logic [1:0] m);
    int waited = 0;
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.in_mode  = m;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      waited++;
    end
    #1;
    chk("in_accept", acc, 1);
  endtask

  // One beat through an empty pipe, checking latency and the result.
  task automatic dir(input logic [IN_W-1:0] x, input logic [1:0] m,
                     input logic [OUT_W-1:0] ed, input logic es, input int ei);
    drive_beat(x, m);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_vld", bus.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat2_vld", bus.out_valid, 1);
    chk("dir_data", bus.out_data, ed);
    chk("dir_sat", bus.out_sat, es);
    chk("dir_idx", bus.out_idx, ei);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [IN_W-1:0]  dx[12];
  logic [1:0]       dm[12];
  logic [OUT_W-1:0] de[12];
  logic             ds[12];

  initial begin
    logic [IN_W-1:0] x15, x25, x10, xmax;
    int gaps;

    x15 = 3;  x15 = x15 << 89;
    x25 = 5;  x25 = x25 << 89;
    x10 = 1;  x10 = x10 << 90;
    xmax = '1;
    for (int i = 0; i < 4; i++) begin
      dx[i] = x15; dm[i] = 2'(i); de[i] = (i == 0) ? 30'd1 : 30'd2; ds[i] = 1'b0;
      dx[6+i] = x10; dm[6+i] = 2'(i); de[6+i] = 30'd1; ds[6+i] = 1'b0;
    end
    dx[4] = x25;  dm[4] = RND_HALF_UP; de[4] = 30'd3; ds[4] = 1'b0;
    dx[5] = x25;  dm[5] = RND_EVEN;    de[5] = 30'd2; ds[5] = 1'b0;
    dx[10] = xmax; dm[10] = RND_HALF_UP; de[10] = 30'h3FFFFFFF; ds[10] = 1'b1;
    dx[11] = xmax; dm[11] = RND_TRUNC;   de[11] = 30'h3FFFFFFF; ds[11] = 1'b0;

    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = RND_TRUNC;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed rounding cases
    for (int i = 0; i < 12; i++) dir(dx[i], dm[i], de[i], ds[i], i);

    // Continuous input, output stalled for 5 cycles
    gaps = 0;
    fork
      begin
        for (int i = 0; i < 50; i++) drive_beat(rand_x(), 2'($urandom_range(0, 3)));
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (!bus.out_valid) gaps++;
        end
        chk("no_gaps", gaps, 0);
      end
    join
    drain();

    // Index wrap over 1025 beats from a fresh reset
    do_reset();
    for (int i = 0; i < N + 1; i++) drive_beat(rand_x(), 2'($urandom_range(0, 3)));
    bus.in_valid = 1'b0;
    drain();
    chk("wrap_n_last", n_last, 1);
    chk("wrap_last_idx", last_at_idx, N - 1);
    chk("beat1025_idx", seen_idx, 0);
    chk("beat1025_last", seen_last, 0);

    // Reset with two beats held in the pipe
    bus.out_ready = 1'b0;
    drive_beat(rand_x(), RND_EVEN);
    drive_beat(rand_x(), RND_CEIL);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    chk("pre_rst_idx", bus.out_idx, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_out_idx", bus.out_idx, 0);
    chk("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    dir(x10, RND_CEIL, 30'd1, 1'b0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
